// File: rtl/ram_stream_pkg.sv
// Shared op codes and FSM state encodings for the RAM stream loader.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_DUMP   = 2'd1,
        OP_VERIFY = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DUMP   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/ram_stream_counter.sv
// Address/remaining-word counter; address wraps modulo 2^ADDR_W.
module ram_stream_counter #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   remaining,
    output logic              zero
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load) begin
            addr_d      = base;
            remaining_d = len;
        end else if (step) begin
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr      = addr_q;
    assign remaining = remaining_q;
    assign zero      = (remaining_q == '0);

endmodule

// File: rtl/ram_stream_loader.sv
// Streaming LOAD / DUMP / VERIFY initiator for the RAM8..RAM16K hierarchy.
module ram_stream_loader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count
);

    state_e            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [15:0]       err_q, err_d;

    logic              cnt_load, cnt_step, rem_zero;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              drain_ok;
    op_e               op;

    assign op = op_e'(cmd_op);

    ram_stream_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .step      (cnt_step),
        .base      (cmd_base),
        .len       (cmd_len),
        .addr      (addr),
        .remaining (remaining),
        .zero      (rem_zero)
    );

    // Output register may take a new word when empty or when its word leaves now.
    assign drain_ok = !m_valid_q || m_ready;

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        err_d     = err_q;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    err_d    = '0;
                    if (cmd_len == '0 || op == OP_NOP) begin
                        state_d = ST_DONE;
                    end else if (op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (op == OP_DUMP) begin
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    cnt_step = 1'b1;
                    if (remaining == (ADDR_W + 1)'(1)) state_d = ST_DONE;
                end
            end
            ST_VERIFY: begin
                if (s_valid) begin
                    cnt_step = 1'b1;
                    if (s_data != mem_q && err_q != ERR_MAX) err_d = err_q + 16'd1;
                    if (remaining == (ADDR_W + 1)'(1)) state_d = ST_DONE;
                end
            end
            ST_DUMP: begin
                if (!rem_zero && drain_ok) begin
                    cnt_step  = 1'b1;
                    m_data_d  = mem_q;
                    m_valid_d = 1'b1;
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                end
                if (rem_zero && drain_ok) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    // Gating with reset keeps an aborting cycle from writing one more word.
    assign s_ready   = !reset && (state_q == ST_LOAD || state_q == ST_VERIFY);
    assign mem_load  = !reset && state_q == ST_LOAD && s_valid;
    assign mem_data  = s_data;
    assign mem_addr  = addr;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign err_count = err_q;

endmodule
